led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 18: number of LED outputs; SHALL be >= 2.
REQ-002 Parameter DIV, default 2500000: ck cycles per pattern step; SHALL be >= 1.
REQ-003 ck  input  1: single clock; all state updates occur on rising edge.
REQ-004 rs  input  1: reset; asynchronous, active-high.
REQ-005 en  input  1: 1 = run; 0 = freeze divider and pattern.
REQ-006 mode  input  2: 0 OFF, 1 BLINK, 2 WAVE, 3 CHASE.
REQ-007 led  output  WIDTH: registered LED pattern, bit WIDTH-1 = leftmost.
REQ-008 cycle_done  output  1: registered one-ck pulse when a full pattern period completes.

Function
REQ-009 Divider counts 0..DIV-1 while en=1; internal tick SHALL assert for one ck when count = DIV-1, then count wraps to 0.
REQ-010 Pattern state and led SHALL change only on ck edges where tick=1 and en=1.
REQ-011 en=0: divider count, state, position counter and led SHALL hold; cycle_done = 0.
REQ-012 mode is registered internally; a change in mode (any value differing from the stored mode) SHALL, on the next ck edge: store the new mode, clear led to 0, clear divider and position counter, enter START state; no cycle_done.
REQ-013 A mode change SHALL take priority over a tick in the same cycle.
REQ-014 States: START, FILL_DN, CLR_A, FILL_UP, CLR_B, BLINK_ON, BLINK_OFF, CHASE_DN, CHASE_UP.
REQ-015 OFF: led SHALL stay 0; state stays START; cycle_done never asserts.
REQ-016 BLINK: START -tick-> BLINK_ON (led all ones) -tick-> BLINK_OFF (led 0, cycle_done pulse) -tick-> BLINK_ON ...; period 2 ticks.
REQ-017 WAVE, FILL_DN: tick k (k=1..WIDTH) sets led to top k bits = 1; after k=WIDTH next tick -> CLR_A.
REQ-018 WAVE, CLR_A: led = 0 for one tick, then FILL_UP.
REQ-019 WAVE, FILL_UP: tick k (k=1..WIDTH) sets led to bottom k bits = 1; after k=WIDTH next tick -> CLR_B.
REQ-020 WAVE, CLR_B: led = 0, cycle_done pulse, next tick -> FILL_DN with k=1; period 2*WIDTH+2 ticks.
REQ-021 CHASE: exactly one led bit set; first tick sets bit WIDTH-1; CHASE_DN moves bit down one per tick to bit 0, then CHASE_UP moves up to bit WIDTH-1, then reverses; endpoints shown once per reversal; period 2*WIDTH-2 ticks.
REQ-022 CHASE: cycle_done SHALL pulse on the tick where bit WIDTH-1 is re-entered from CHASE_UP.
REQ-023 Position counter width SHALL be $clog2(WIDTH+1); it SHALL never exceed WIDTH.
REQ-024 cycle_done SHALL be 0 in every cycle other than those specified in REQ-016, REQ-020 and REQ-022.

Reset
REQ-025 rs=1 SHALL immediately force: led = 0, cycle_done = 0, divider = 0, position = 0, state = START, stored mode = 0 (OFF).
REQ-026 After rs deasserts, a nonzero mode input SHALL be treated as a mode change (REQ-012).
REQ-027 rs asserted mid-pattern SHALL abandon the pattern with no cycle_done pulse.

Structure
REQ-028 Shared package led_pkg SHALL hold mode encodings (MODE_OFF, MODE_BLINK, MODE_WAVE, MODE_CHASE) and the state enumeration.
REQ-029 Divider SHALL be a separate sub-module tick_gen (parameter DIV; ports ck, rs, en, clr, tick).

Verification (WIDTH=4, DIV=3)
REQ-030 rs pulse mid-WAVE -> led=0, cycle_done=0 asynchronously; after release with mode=2, first led=1000 exactly 3 ck after mode registration.
REQ-031 mode=2 held -> led per tick: 1000,1100,1110,1111,0000,0001,0011,0111,1111,0000(cycle_done=1),1000; period 10 ticks = 30 ck.
REQ-032 mode=3 held -> led: 1000,0100,0010,0001,0010,0100,1000(cycle_done=1),0100; period 6 ticks.
REQ-033 mode=1 held -> led 1111,0000(cycle_done=1),1111; en=0 for 10 ck during 1111 -> led holds 1111, then next change exactly 3 active ck after en=1 returns, counting from the frozen divider value.
REQ-034 Switch mode 2->3 in the same cycle as a tick while led=1110 -> next edge led=0000, no cycle_done, first CHASE led=1000 after 3 ck.
REQ-035 mode=0 for 100 ck -> led=0000 throughout, cycle_done never asserts.

Source files
------------

// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern generator: mode values and the
// pattern state enumeration.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_WAVE  = 2'd2,
        MODE_CHASE = 2'd3
    } mode_t;

    typedef enum logic [3:0] {
        START     = 4'd0,
        FILL_DN   = 4'd1,
        CLR_A     = 4'd2,
        FILL_UP   = 4'd3,
        CLR_B     = 4'd4,
        BLINK_ON  = 4'd5,
        BLINK_OFF = 4'd6,
        CHASE_DN  = 4'd7,
        CHASE_UP  = 4'd8
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// Step-rate divider: counts 0..DIV-1 while enabled and strobes tick on the
// last count. clr restarts the count from zero.
module tick_gen
    import led_pkg::*;
#(
    parameter int DIV = 2500000
) (
    input  logic ck,
    input  logic rs,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign tick = en & (r_cnt == LAST);

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: OFF, BLINK, WAVE (fill/clear both directions) and
// CHASE (single bouncing bit), stepped by tick_gen.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DIV   = 2500000
) (
    input  logic             ck,
    input  logic             rs,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led,
    output logic             cycle_done
);

    localparam int PW = $clog2(WIDTH + 1);
    localparam logic [PW-1:0]    P_FULL = PW'(WIDTH);
    localparam logic [PW-1:0]    P_TOP  = PW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONES   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    mode_t            r_mode;
    state_t           r_state;
    logic [PW-1:0]    r_pos;
    logic [WIDTH-1:0] r_led;
    logic             r_cycle_done;

    state_t           w_state;
    logic [PW-1:0]    w_pos;
    logic [WIDTH-1:0] w_led;
    logic             w_cycle_done;
    logic             w_tick;
    logic             w_mode_chg;

    assign w_mode_chg = (mode != r_mode);

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .ck   (ck),
        .rs   (rs),
        .en   (en),
        .clr  (w_mode_chg),
        .tick (w_tick)
    );

    // A mode change wins over a tick; otherwise state only moves on an enabled tick.
    always_comb begin
        w_state      = r_state;
        w_pos        = r_pos;
        w_led        = r_led;
        w_cycle_done = 1'b0;
        if (w_mode_chg) begin
            w_state = START;
            w_pos   = '0;
            w_led   = '0;
        end else if (en && w_tick) begin
            case (r_mode)
                MODE_BLINK: begin
                    if (r_state == BLINK_ON) begin
                        w_state      = BLINK_OFF;
                        w_led        = '0;
                        w_cycle_done = 1'b1;
                    end else begin
                        w_state = BLINK_ON;
                        w_led   = ONES;
                    end
                end
                MODE_WAVE: begin
                    case (r_state)
                        START, CLR_B: begin
                            w_state = FILL_DN;
                            w_pos   = PW'(1);
                            w_led   = ~(ONES >> 1);
                        end
                        FILL_DN: begin
                            if (r_pos == P_FULL) begin
                                w_state = CLR_A;
                                w_pos   = '0;
                                w_led   = '0;
                            end else begin
                                w_pos = r_pos + PW'(1);
                                w_led = ~(ONES >> (r_pos + PW'(1)));
                            end
                        end
                        CLR_A: begin
                            w_state = FILL_UP;
                            w_pos   = PW'(1);
                            w_led   = ONE;
                        end
                        FILL_UP: begin
                            if (r_pos == P_FULL) begin
                                w_state      = CLR_B;
                                w_pos        = '0;
                                w_led        = '0;
                                w_cycle_done = 1'b1;
                            end else begin
                                w_pos = r_pos + PW'(1);
                                w_led = ~(ONES << (r_pos + PW'(1)));
                            end
                        end
                        default: begin
                            w_state = START;
                            w_pos   = '0;
                            w_led   = '0;
                        end
                    endcase
                end
                MODE_CHASE: begin
                    // r_pos holds the index of the lit bit while chasing.
                    case (r_state)
                        START: begin
                            w_state = CHASE_DN;
                            w_pos   = P_TOP;
                            w_led   = ONE << P_TOP;
                        end
                        CHASE_DN: begin
                            w_pos = r_pos - PW'(1);
                            w_led = ONE << (r_pos - PW'(1));
                            if (r_pos == PW'(1)) begin
                                w_state = CHASE_UP;
                            end else begin
                                w_state = CHASE_DN;
                            end
                        end
                        CHASE_UP: begin
                            w_pos = r_pos + PW'(1);
                            w_led = ONE << (r_pos + PW'(1));
                            if (r_pos == (P_TOP - PW'(1))) begin
                                w_state      = CHASE_DN;
                                w_cycle_done = 1'b1;
                            end else begin
                                w_state = CHASE_UP;
                            end
                        end
                        default: begin
                            w_state = START;
                            w_pos   = '0;
                            w_led   = '0;
                        end
                    endcase
                end
                default: begin
                    w_state = START;
                    w_pos   = '0;
                    w_led   = '0;
                end
            endcase
        end else begin
            w_cycle_done = 1'b0;
        end
    end

    // State, stored mode and registered outputs.
    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            r_mode       <= MODE_OFF;
            r_state      <= START;
            r_pos        <= '0;
            r_led        <= '0;
            r_cycle_done <= 1'b0;
        end else begin
            r_mode       <= mode_t'(mode);
            r_state      <= w_state;
            r_pos        <= w_pos;
            r_led        <= w_led;
            r_cycle_done <= w_cycle_done;
        end
    end

    assign led        = r_led;
    assign cycle_done = r_cycle_done;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed table-driven bench for led_pattern_gen with WIDTH=4, DIV=3.
module tb_led_pattern_gen;

    localparam int W = 4;
    localparam int D = 3;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        int         ncyc;
        logic [3:0] led;
        logic       cd;
    } vec_t;

    logic         ck = 1'b0;
    logic         rs;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] led;
    logic         cycle_done;

    int   vectors     = 0;
    int   miscompares = 0;
    int   pulses      = 0;
    vec_t tbl[$];

    always #5 ck = ~ck;

    led_pattern_gen #(
        .WIDTH (W),
        .DIV   (D)
    ) dut (
        .ck         (ck),
        .rs         (rs),
        .en         (en),
        .mode       (mode),
        .led        (led),
        .cycle_done (cycle_done)
    );

    // Count every cycle_done pulse to catch spurious ones between checkpoints.
    always @(negedge ck) begin
        if (cycle_done === 1'b1) pulses++;
    end

    task automatic run(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] exp_led, input logic exp_cd);
        vectors++;
        if (led !== exp_led || cycle_done !== exp_cd) begin
            miscompares++;
            $display("FAIL %s: led=%b cycle_done=%b, expected led=%b cycle_done=%b",
                     name, led, cycle_done, exp_led, exp_cd);
        end
    endtask

    task automatic add(input logic e, input logic [1:0] m, input int n,
                       input logic [3:0] l, input logic c);
        vec_t v;
        v.en = e; v.mode = m; v.ncyc = n; v.led = l; v.cd = c;
        tbl.push_back(v);
    endtask

    initial begin
        int bad;
        // WAVE: registration edge, then first step 3 ck later, period 10 ticks
        add(1'b1, 2'd2, 1, 4'b0000, 1'b0);
        add(1'b1, 2'd2, 2, 4'b0000, 1'b0);
        add(1'b1, 2'd2, 1, 4'b1000, 1'b0);
        add(1'b1, 2'd2, 3, 4'b1100, 1'b0);
        add(1'b1, 2'd2, 3, 4'b1110, 1'b0);
        add(1'b1, 2'd2, 3, 4'b1111, 1'b0);
        add(1'b1, 2'd2, 3, 4'b0000, 1'b0);
        add(1'b1, 2'd2, 3, 4'b0001, 1'b0);
        add(1'b1, 2'd2, 3, 4'b0011, 1'b0);
        add(1'b1, 2'd2, 3, 4'b0111, 1'b0);
        add(1'b1, 2'd2, 3, 4'b1111, 1'b0);
        add(1'b1, 2'd2, 3, 4'b0000, 1'b1);
        add(1'b1, 2'd2, 3, 4'b1000, 1'b0);
        add(1'b1, 2'd2, 3, 4'b1100, 1'b0);
        add(1'b1, 2'd2, 3, 4'b1110, 1'b0);
        // switch to CHASE in the very cycle a tick is due
        add(1'b1, 2'd2, 2, 4'b1110, 1'b0);
        add(1'b1, 2'd3, 1, 4'b0000, 1'b0);
        add(1'b1, 2'd3, 2, 4'b0000, 1'b0);
        add(1'b1, 2'd3, 1, 4'b1000, 1'b0);
        add(1'b1, 2'd3, 3, 4'b0100, 1'b0);
        add(1'b1, 2'd3, 3, 4'b0010, 1'b0);
        add(1'b1, 2'd3, 3, 4'b0001, 1'b0);
        add(1'b1, 2'd3, 3, 4'b0010, 1'b0);
        add(1'b1, 2'd3, 3, 4'b0100, 1'b0);
        add(1'b1, 2'd3, 3, 4'b1000, 1'b1);
        add(1'b1, 2'd3, 3, 4'b0100, 1'b0);
        // BLINK with a 10-cycle freeze during 1111
        add(1'b1, 2'd1, 1, 4'b0000, 1'b0);
        add(1'b1, 2'd1, 3, 4'b1111, 1'b0);
        add(1'b1, 2'd1, 3, 4'b0000, 1'b1);
        add(1'b1, 2'd1, 3, 4'b1111, 1'b0);
        add(1'b0, 2'd1, 10, 4'b1111, 1'b0);
        add(1'b1, 2'd1, 2, 4'b1111, 1'b0);
        add(1'b1, 2'd1, 1, 4'b0000, 1'b1);
        add(1'b1, 2'd1, 3, 4'b1111, 1'b0);

        rs = 1'b1; en = 1'b1; mode = 2'd0;
        #2;
        chk("reset_state", 4'b0000, 1'b0);
        @(posedge ck); #1;
        rs = 1'b0;
        run(4);
        chk("off_idle", 4'b0000, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            en   = tbl[i].en;
            mode = tbl[i].mode;
            run(tbl[i].ncyc);
            chk($sformatf("vec%0d", i), tbl[i].led, tbl[i].cd);
        end

        // OFF held 100 ck: led and cycle_done must stay low every cycle
        en = 1'b1; mode = 2'd0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            run(1);
            if (led !== 4'b0000 || cycle_done !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL off_hold: %0d bad cycles, expected 0", bad);
        end

        // Reset mid-WAVE: asynchronous clear, then restart 3 ck after registration
        mode = 2'd2;
        run(4);
        run(3);
        chk("wave_pre_rs", 4'b1100, 1'b0);
        #3 rs = 1'b1;
        #1;
        chk("rs_async", 4'b0000, 1'b0);
        @(posedge ck); #1;
        rs = 1'b0;
        run(1);
        chk("rs_reg", 4'b0000, 1'b0);
        run(2);
        chk("rs_wait", 4'b0000, 1'b0);
        run(1);
        chk("rs_first", 4'b1000, 1'b0);
        run(3);
        chk("rs_second", 4'b1100, 1'b0);

        // two BLINK, one WAVE, one CHASE pulse expected in total
        vectors++;
        if (pulses != 4) begin
            miscompares++;
            $display("FAIL pulse_count: saw %0d cycle_done pulses, expected 4", pulses);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
